// File: rtl/filter_loader_if.sv
// Serial link and filter-side outputs of the filter loader, bundled as one port.
// The host drives the 3-wire link; the loader drives the filter inputs and strobes.
interface filter_loader_if #(
  parameter int unsigned W = 16
) ();
  logic         cs_n;
  logic         sclk;
  logic         mosi;
  logic [W-1:0] x;
  logic [W-1:0] a1;
  logic [W-1:0] b0;
  logic [W-1:0] b1;
  logic         sample_stb;
  logic         coef_stb;
  logic         frame_err;

  modport master (
    output cs_n, sclk, mosi,
    input  x, a1, b0, b1, sample_stb, coef_stb, frame_err
  );

  modport slave (
    input  cs_n, sclk, mosi,
    output x, a1, b0, b1, sample_stb, coef_stb, frame_err
  );
endinterface

// File: rtl/filter_loader.sv
// Serial front end for the first-order IIR filter. Oversamples a cs_n/sclk/mosi link,
// collects AW+W bit frames and writes the sample register or double-buffered coefficients.
module filter_loader #(
  parameter int unsigned  W           = 16,
  parameter int unsigned  AW          = 8,
  parameter int unsigned  SYNC_STAGES = 2,
  parameter logic [W-1:0] A1_RST      = '0,
  parameter logic [W-1:0] B0_RST      = '0,
  parameter logic [W-1:0] B1_RST      = '0
) (
  input logic            clk,
  input logic            rst,
  filter_loader_if.slave bus
);

  localparam int unsigned    FL       = AW + W;
  localparam int unsigned    CW       = $clog2(FL + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(FL);
  localparam logic [CW-1:0]  CNT_OVF  = CW'(FL + 1);

  localparam logic [AW-1:0] ADDR_X      = AW'(0);
  localparam logic [AW-1:0] ADDR_A1     = AW'(1);
  localparam logic [AW-1:0] ADDR_B0     = AW'(2);
  localparam logic [AW-1:0] ADDR_B1     = AW'(3);
  localparam logic [AW-1:0] ADDR_COMMIT = AW'(4);

  typedef enum logic [1:0] {StIdle, StShift, StDecode} state_e;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_d, sclk_d, mosi_d;
  logic                   cs_fall_q, cs_rise_q, sclk_rise_q;

  state_e         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [FL-1:0]  shreg_q, shreg_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic [W-1:0]   sa1_q, sa1_d, sb0_q, sb0_d, sb1_q, sb1_d;
  logic           sample_q, sample_d, coef_q, coef_d, err_q, err_d;

  logic [AW-1:0]  addr;
  logic [W-1:0]   data;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign addr = shreg_q[FL-1:W];
  assign data = shreg_q[W-1:0];

  // Synchronisers, edge-detect stage and registered edge pulses. The cs chain resets low so a
  // cs_n already low at reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync     <= '0;
      sclk_sync   <= '0;
      mosi_sync   <= '0;
      cs_d        <= 1'b0;
      sclk_d      <= 1'b0;
      mosi_d      <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      cs_d        <= cs_s;
      sclk_d      <= sclk_s;
      mosi_d      <= mosi_s;  // stays aligned with sclk_rise_q
      cs_fall_q   <= cs_d & ~cs_s;
      cs_rise_q   <= ~cs_d & cs_s;
      sclk_rise_q <= ~sclk_d & sclk_s;
    end
  end

  // Next-state, shift register, decode and output register updates.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shreg_d  = shreg_q;
    x_d      = x_q;
    a1_d     = a1_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    sa1_d    = sa1_q;
    sb0_d    = sb0_q;
    sb1_d    = sb1_q;
    sample_d = 1'b0;
    coef_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall_q) begin
          state_d = StShift;
          count_d = '0;
        end
      end
      StShift: begin
        if (sclk_rise_q) begin
          shreg_d = {shreg_q[FL-2:0], mosi_d};
          // Saturating at FL+1 keeps over-long frames distinguishable from full ones.
          if (count_q != CNT_OVF) count_d = count_q + 1'b1;
        end
        if (cs_rise_q) state_d = StDecode;
      end
      StDecode: begin
        state_d = StIdle;
        if (count_q != CNT_FULL) begin
          err_d = 1'b1;
        end else begin
          case (addr)
            ADDR_X: begin
              x_d      = data;
              sample_d = 1'b1;
            end
            ADDR_A1: sa1_d = data;
            ADDR_B0: sb0_d = data;
            ADDR_B1: sb1_d = data;
            ADDR_COMMIT: begin
              a1_d   = sa1_q;
              b0_d   = sb0_q;
              b1_d   = sb1_q;
              coef_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      shreg_q  <= '0;
      x_q      <= '0;
      a1_q     <= A1_RST;
      b0_q     <= B0_RST;
      b1_q     <= B1_RST;
      sa1_q    <= A1_RST;
      sb0_q    <= B0_RST;
      sb1_q    <= B1_RST;
      sample_q <= 1'b0;
      coef_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shreg_q  <= shreg_d;
      x_q      <= x_d;
      a1_q     <= a1_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      sa1_q    <= sa1_d;
      sb0_q    <= sb0_d;
      sb1_q    <= sb1_d;
      sample_q <= sample_d;
      coef_q   <= coef_d;
      err_q    <= err_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.a1         = a1_q;
  assign bus.b0         = b0_q;
  assign bus.b1         = b1_q;
  assign bus.sample_stb = sample_q;
  assign bus.coef_stb   = coef_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_filter_loader.sv
// Bench for filter_loader: directed serial frames, a frame-level reference model checked
// every cycle, and literal expectations at key points.
module tb_filter_loader;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 8;
  localparam logic [15:0] A1R = 16'h0000;
  localparam logic [15:0] B0R = 16'h0000;
  localparam logic [15:0] B1R = 16'h0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_loader_if #(.W(W)) bus ();

  filter_loader #(
    .W(W), .AW(AW), .SYNC_STAGES(2), .A1_RST(A1R), .B0_RST(B0R), .B1_RST(B1R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame posts from the driver (driver is the only writer).
  int          fr_seq = 0;
  int          fr_bits;
  logic [31:0] fr_val;
  int          fr_cyc;
  // Literal expectation posts from the driver.
  int          lit_seq = 0;
  string       lit_name;
  logic [15:0] lit_x, lit_a1, lit_b0, lit_b1;

  // Model state and counters (checker is the only writer).
  int          checks = 0;
  int          errors = 0;
  int          seen_seq = 0;
  int          lit_seen = 0;
  logic [15:0] m_x, m_a1, m_b0, m_b1, m_sa1, m_sb0, m_sb1;
  bit          pend = 1'b0;
  int          pend_cyc;
  int          pend_kind;  // 0 none, 1 sample, 2 commit, 3 error
  logic [15:0] pend_data;
  logic        e_s, e_c, e_f;

  // Reference model and per-cycle compare: a frame's visible effect lands 4 clocks after the
  // first clock that sees cs_n high.
  always @(negedge clk) begin
    e_s = 1'b0;
    e_c = 1'b0;
    e_f = 1'b0;
    if (rst) begin
      m_x = '0; m_a1 = A1R; m_b0 = B0R; m_b1 = B1R;
      m_sa1 = A1R; m_sb0 = B0R; m_sb1 = B1R;
      pend = 1'b0;
      seen_seq = fr_seq;
    end else begin
      if (fr_seq != seen_seq) begin
        seen_seq  = fr_seq;
        pend      = 1'b1;
        pend_cyc  = fr_cyc + 5;
        pend_kind = 0;
        pend_data = fr_val[15:0];
        if (fr_bits != 24) pend_kind = 3;
        else begin
          case (fr_val[23:16])
            8'h00: pend_kind = 1;
            8'h01: m_sa1 = fr_val[15:0];
            8'h02: m_sb0 = fr_val[15:0];
            8'h03: m_sb1 = fr_val[15:0];
            8'h04: pend_kind = 2;
            default: pend_kind = 3;
          endcase
        end
      end
      if (pend && cyc == pend_cyc) begin
        case (pend_kind)
          1: begin m_x = pend_data; e_s = 1'b1; end
          2: begin m_a1 = m_sa1; m_b0 = m_sb0; m_b1 = m_sb1; e_c = 1'b1; end
          3: e_f = 1'b1;
          default: ;
        endcase
        pend = 1'b0;
      end
      checks++;
      if ({bus.x, bus.a1, bus.b0, bus.b1, bus.sample_stb, bus.coef_stb, bus.frame_err} !==
          {m_x, m_a1, m_b0, m_b1, e_s, e_c, e_f}) begin
        errors++;
        $display("FAIL cycle %0d outputs: got x=%h a1=%h b0=%h b1=%h stb(s,c,e)=%b%b%b, expected x=%h a1=%h b0=%h b1=%h stb=%b%b%b",
                 cyc, bus.x, bus.a1, bus.b0, bus.b1, bus.sample_stb, bus.coef_stb,
                 bus.frame_err, m_x, m_a1, m_b0, m_b1, e_s, e_c, e_f);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        checks++;
        if ({bus.x, bus.a1, bus.b0, bus.b1} !== {lit_x, lit_a1, lit_b0, lit_b1}) begin
          errors++;
          $display("FAIL %s: got x=%h a1=%h b0=%h b1=%h, expected x=%h a1=%h b0=%h b1=%h",
                   lit_name, bus.x, bus.a1, bus.b0, bus.b1, lit_x, lit_a1, lit_b0, lit_b1);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = v[i];
      cycles(4);
      bus.sclk = 1'b1;
      cycles(4);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [31:0] v);
    bus.cs_n = 1'b0;
    cycles(4);
    shift_bits(n, v);
    cycles(4);
    bus.cs_n = 1'b1;
    fr_bits  = n;
    fr_val   = v;
    fr_cyc   = cyc;
    fr_seq++;
    cycles(8);
  endtask

  task automatic expect_lit(input string name, input logic [15:0] ex, input logic [15:0] ea1,
                            input logic [15:0] eb0, input logic [15:0] eb1);
    lit_name = name;
    lit_x    = ex;
    lit_a1   = ea1;
    lit_b0   = eb0;
    lit_b1   = eb1;
    lit_seq++;
    cycles(1);
  endtask

  initial begin
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(2);
    expect_lit("reset_state", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    frame(24, 32'h00_3C00);
    expect_lit("sample_write", 16'h3C00, 16'h0000, 16'h0000, 16'h0000);

    frame(24, 32'h01_3800);
    frame(24, 32'h02_3400);
    expect_lit("shadow_only", 16'h3C00, 16'h0000, 16'h0000, 16'h0000);
    frame(24, 32'h04_0000);
    expect_lit("commit_1", 16'h3C00, 16'h3800, 16'h3400, 16'h0000);

    frame(23, 32'h00_1234 >> 1);
    frame(25, 32'h01_2345);
    frame(0, 32'h0);
    expect_lit("bad_lengths", 16'h3C00, 16'h3800, 16'h3400, 16'h0000);

    frame(24, 32'h07_FFFF);
    frame(24, 32'h04_0000);
    expect_lit("bad_addr_commit", 16'h3C00, 16'h3800, 16'h3400, 16'h0000);

    frame(24, 32'h03_1111);
    frame(24, 32'h04_ABCD);
    expect_lit("commit_b1", 16'h3C00, 16'h3800, 16'h3400, 16'h1111);

    // Shadow a1 written, then reset mid-frame: shadow must return to its reset value.
    frame(24, 32'h01_7777);
    bus.cs_n = 1'b0;
    cycles(4);
    shift_bits(12, 32'h001);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    shift_bits(12, 32'h234);
    cycles(4);
    bus.cs_n = 1'b1;
    cycles(8);
    expect_lit("after_reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    frame(24, 32'h00_5555);
    expect_lit("sample_after_reset", 16'h5555, 16'h0000, 16'h0000, 16'h0000);
    frame(24, 32'h04_0000);
    expect_lit("commit_after_reset", 16'h5555, 16'h0000, 16'h0000, 16'h0000);

    cycles(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
